// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between instruction fetch and MEM-stage data access.
// Build macro MEMARB_FAIRNESS_EN lets a waiting fetch win after MAX_DSTREAK back-to-back data grants.
module mem_arbiter #(
    parameter int unsigned LAT         = 2,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        stall_f,
    output logic        stall_m,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam int unsigned CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q;      // 1 = data access owns the transaction
    logic          start;
    logic          finish;
    logic          take_data;
    logic          grant_data;

    if (LAT < 1 || MAX_DSTREAK < 1) begin : g_param_check
        $error("mem_arbiter: LAT and MAX_DSTREAK must be at least 1");
    end

`ifdef MEMARB_FAIRNESS_EN
    localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);

    logic [SW-1:0] streak_q;
    logic          fetch_turn;

    // Fetch takes its turn once data has won MAX_DSTREAK times in a row over it.
    assign fetch_turn = i_req && (streak_q == SW'(MAX_DSTREAK));
    assign grant_data = d_req && !fetch_turn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q <= '0;
        end else if (start) begin
            if (take_data && i_req) begin
                streak_q <= streak_q + SW'(1);
            end else begin
                streak_q <= '0;
            end
        end
    end
`else
    assign grant_data = d_req;
`endif

    // Stall requests follow the live request lines until the matching done pulse.
    assign stall_f = i_req & ~i_done;
    assign stall_m = d_req & ~d_done;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and transaction control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start     = 1'b0;
        finish    = 1'b0;
        take_data = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req || i_req) begin
                    start     = 1'b1;
                    take_data = grant_data;
                    cnt_d     = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CW'(LAT)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latched request, memory strobes, read-data capture and done pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q  <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
        end else begin
            mem_req <= start;
            i_done  <= finish && !owner_q;
            d_done  <= finish && owner_q;
            if (start) begin
                owner_q <= take_data;
                if (take_data) begin
                    mem_addr <= d_addr;
                    mem_we   <= d_we;
                    mem_wd   <= d_wdata;
                end else begin
                    mem_addr <= i_addr;
                    mem_we   <= 1'b0;
                    mem_wd   <= '0;
                end
            end
            if (finish && !owner_q) begin
                i_rdata <= mem_rd;
            end
            // Stores complete without touching the load data register.
            if (finish && owner_q && !mem_we) begin
                d_rdata <= mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a latency-accurate memory model and a done scoreboard.
// Fairness expectations switch on MEMARB_FAIRNESS_EN to match the design build.
module tb_mem_arbiter;

    localparam logic [31:0] KEY = 32'h8C480004;

    typedef struct {
        logic        dat;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    // LAT=2 instance
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wd, mem_rd;
    logic        i_done, d_done, stall_f, stall_m, mem_req, mem_we;

    // LAT=1 instance, fetch side only exercised
    logic        i_req1, d_req1, d_we1;
    logic [31:0] i_addr1, d_addr1, d_wdata1;
    logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wd1, mem_rd1;
    logic        i_done1, d_done1, stall_f1, stall_m1, mem_req1, mem_we1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e;

    int          rq_cyc = -100;
    int          rq1_cyc = -100;
    logic [31:0] rq_addr = '0;
    logic [31:0] rq1_addr = '0;

    mem_arbiter #(.LAT(2), .MAX_DSTREAK(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    mem_arbiter #(.LAT(1), .MAX_DSTREAK(4)) dut1 (
        .clk(clk), .reset(reset),
        .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_done(i_done1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_rdata(d_rdata1), .d_done(d_done1),
        .stall_f(stall_f1), .stall_m(stall_m1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wd(mem_wd1), .mem_rd(mem_rd1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns addr^KEY only in the cycle exactly LAT after the request strobe.
    always @(negedge clk) begin
        if (mem_req) begin
            rq_cyc  = cyc;
            rq_addr = mem_addr;
        end
        if (mem_req1) begin
            rq1_cyc  = cyc;
            rq1_addr = mem_addr1;
        end
    end

    assign mem_rd  = (cyc == rq_cyc + 2)  ? (rq_addr ^ KEY)  : 32'hBAD0BAD0;
    assign mem_rd1 = (cyc == rq1_cyc + 1) ? (rq1_addr ^ KEY) : 32'hBAD0BAD0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse must match the next expected completion
    always @(negedge clk) begin
        if (!reset) begin
            if (i_done || d_done) begin
                chk("done_exclusive", 32'(i_done & d_done), 32'd0);
                chk("done_expected", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("done_owner", 32'(d_done), 32'(e.dat));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("done_rdata", e.dat ? d_rdata : i_rdata, e.val);
                end
            end
            if (i_done1 || d_done1) begin
                chk("l1_done_expected", 32'(q1.size() != 0), 32'd1);
                chk("l1_d_done_low", 32'(d_done1), 32'd0);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("l1_done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("l1_done_rdata", i_rdata1, e.val);
                end
            end
        end
    end

    initial begin
        int c0;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        i_req1 = 0; i_addr1 = '0; d_req1 = 0; d_we1 = 0; d_addr1 = '0; d_wdata1 = '0;

        // Reset state
        tick(3);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_done", 32'({i_done, d_done}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_stalls", 32'({stall_f, stall_m}), 32'd0);
        chk("rst_l1_mem_req", 32'(mem_req1), 32'd0);
        tick(1);
        reset = 0;
        tick(1);

        // Single fetch
        i_req = 1; i_addr = 32'h00400000; c0 = cyc;
        q0.push_back('{1'b0, 32'h8C080004, c0 + 4});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("f1_mem_req_c%0d", k), 32'(mem_req), 32'(k == 1));
            chk($sformatf("f1_stall_f_c%0d", k), 32'(stall_f), 32'(k < 4));
            if (k == 1) chk("f1_mem_addr", mem_addr, 32'h00400000);
            tick(1);
        end
        i_req = 0;

        // Simultaneous fetch and load: data first
        i_req = 1; i_addr = 32'h00400010; d_req = 1; d_we = 0; d_addr = 32'h10010000; c0 = cyc;
        q0.push_back('{1'b1, 32'h10010000 ^ KEY, c0 + 4});
        q0.push_back('{1'b0, 32'h00400010 ^ KEY, c0 + 9});
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("both_mem_req_c%0d", k), 32'(mem_req), 32'(k == 1 || k == 6));
            chk($sformatf("both_stall_f_c%0d", k), 32'(stall_f), 32'(k != 9));
            chk($sformatf("both_stall_m_c%0d", k), 32'(stall_m), 32'(k < 4));
            if (k == 1) chk("both_addr_data", mem_addr, 32'h10010000);
            if (k == 6) chk("both_addr_fetch", mem_addr, 32'h00400010);
            tick(1);
            if (k == 4) d_req = 0;
        end
        i_req = 0;

        // Store leaves d_rdata alone; write data latched at grant
        d_req = 1; d_we = 1; d_addr = 32'h10010008; d_wdata = 32'hDEADBEEF; c0 = cyc;
        q0.push_back('{1'b1, 32'h10010000 ^ KEY, c0 + 4});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("st_mem_req_c%0d", k), 32'(mem_req), 32'(k == 1));
            if (k >= 1 && k <= 3) begin
                chk($sformatf("st_mem_we_c%0d", k), 32'(mem_we), 32'd1);
                chk($sformatf("st_mem_wd_c%0d", k), mem_wd, 32'hDEADBEEF);
                chk($sformatf("st_mem_addr_c%0d", k), mem_addr, 32'h10010008);
            end
            tick(1);
            if (k == 1) d_wdata = 32'h12345678;
        end
        d_req = 0; d_we = 0;

        // Reset during a load abandons it
        d_req = 1; d_addr = 32'h10010020; c0 = cyc;
        tick(1);
        chk("rr_mem_req_before", 32'(mem_req), 32'd1);
        reset = 1;
        #1;
        chk("rr_mem_req_async", 32'(mem_req), 32'd0);
        chk("rr_d_done", 32'(d_done), 32'd0);
        chk("rr_mem_addr", mem_addr, 32'd0);
        chk("rr_d_rdata", d_rdata, 32'd0);
        chk("rr_stall_m", 32'(stall_m), 32'd1);
        tick(2);
        reset = 0; c0 = cyc;
        q0.push_back('{1'b1, 32'h10010020 ^ KEY, c0 + 4});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rr_restart_mem_req_c%0d", k), 32'(mem_req), 32'(k == 1));
            tick(1);
        end
        d_req = 0;

        // Both requests held continuously
        i_req = 1; i_addr = 32'h00400040; d_req = 1; d_we = 0; d_addr = 32'h10010040; c0 = cyc;
        for (int k = 0; k < 10; k++) begin
`ifdef MEMARB_FAIRNESS_EN
            if (k % 5 == 4) q0.push_back('{1'b0, 32'h00400040 ^ KEY, c0 + 4 + 5 * k});
            else            q0.push_back('{1'b1, 32'h10010040 ^ KEY, c0 + 4 + 5 * k});
`else
            q0.push_back('{1'b1, 32'h10010040 ^ KEY, c0 + 4 + 5 * k});
`endif
        end
        tick(50);
        i_req = 0; d_req = 0;

        // LAT=1 back-to-back fetches with changing address
        c0 = cyc; i_req1 = 1;
        for (int t = 0; t < 4; t++) begin
            i_addr1 = 32'h00400000 + 32'(t * 4);
            q1.push_back('{1'b0, i_addr1 ^ KEY, c0 + 3 + 4 * t});
            tick(1);
            chk($sformatf("l1_mem_req_t%0d", t), 32'(mem_req1), 32'd1);
            chk($sformatf("l1_mem_addr_t%0d", t), mem_addr1, i_addr1);
            tick(3);
        end
        i_req1 = 0;

        for (int w = 0; w < 20 && (q0.size() != 0 || q1.size() != 0); w++) tick(1);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified memory port between instruction fetch (IF stage) and the data access of the MEM stage (LW, SW, LB). The block arbitrates each cycle it is idle, sequences one fixed-latency memory transaction at a time, and returns read data with a one-cycle done pulse. It drives the stall requests that the hazard unit uses to freeze the pipeline. Byte extraction for LB stays in the datapath; this block always moves full words.

## Interface
- LAT, 2, memory read latency in cycles (≥1); counter width is clog2(LAT+1)
- MAX_DSTREAK, 4, consecutive data grants allowed while fetch waits (fairness build only, ≥1)

- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces idle state
- i_req  in  1  fetch request, held until i_done
- i_addr  in  32  fetch word address, stable while i_req is high
- i_rdata  out  32  fetched instruction, valid when i_done is high
- i_done  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = store (SW), 0 = load (LW/LB)
- d_addr  in  32  data address, stable while d_req is high
- d_wdata  in  32  store data
- d_rdata  out  32  load word, valid when d_done is high
- d_done  out  1  one-cycle completion pulse for data
- stall_f  out  1  i_req & ~i_done
- stall_m  out  1  d_req & ~d_done
- mem_req  out  1  one-cycle transaction start to memory
- mem_we  out  1  write enable, qualified by mem_req
- mem_addr  out  32  latched address, held for whole transaction
- mem_wd  out  32  latched write data
- mem_rd  in  32  memory read data, valid exactly LAT cycles after mem_req

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE; all outputs 0 (mem_addr, mem_wd, i_rdata, d_rdata, cnt, owner, streak cleared).
- IDLE: if d_req or i_req, choose winner, latch owner/addr/we/wdata, cnt←0, go BUSY. No request → stay.
- Priority: d_req beats i_req (MEM instruction is older).
- BUSY: mem_req=1 only when cnt==0; mem_addr/mem_we/mem_wd driven from latches throughout. cnt increments each cycle; at cnt==LAT capture mem_rd into owner's rdata register (loads and fetches; stores leave rdata unchanged), go DONE.
- DONE: owner's done=1 for exactly this cycle; → IDLE.
- A request still high in the IDLE cycle following DONE is a new request.
- Requests arriving during BUSY/DONE wait; stall_f/stall_m stay high meanwhile.
- Stores use the same sequence and latency as loads.
- i_done and d_done are never high together.

## Timing
- Request seen in IDLE at cycle 0 → mem_req cycle 1 → mem_rd sampled cycle 1+LAT → done cycle 2+LAT.
- Throughput: one transaction per LAT+3 cycles (IDLE arbitration cycle included).
- i_rdata/d_rdata hold last captured value until next capture for that owner.
- Reset mid-transaction: immediate return to IDLE, done/mem_req deassert asynchronously, transaction abandoned, no capture.
- Requester dropping req during BUSY: transaction still completes, done still pulses; the requester ignores it.

## Configuration
- MEMARB_FAIRNESS_EN defined: streak counter counts data grants made while i_req was high; when streak==MAX_DSTREAK and both requests are pending in IDLE, fetch wins. Streak clears on any fetch grant or on a data grant with i_req low.
- Not defined: strict data priority, fetch can starve indefinitely; no streak logic.

## Test plan
- Single fetch, LAT=2: i_req=1, i_addr=0x00400000 at cycle 0, mem_rd=0x8C080004 at cycle 3 → mem_req only in cycle 1, i_done and i_rdata=0x8C080004 in cycle 4, stall_f low from cycle 4.
- Simultaneous i_req and d_req (load 0x10010000) → data served first (d_done cycle 4), fetch issued mem_req cycle 6, i_done cycle 9.
- Store: d_we=1, d_addr=0x10010008, d_wdata=0xDEADBEEF → mem_we=1 with mem_req in cycle 1, mem_wd stable through cycle 3, d_done cycle 4, d_rdata unchanged.
- Reset asserted during cycle 2 of a load → mem_req/d_done 0 at once, state IDLE, no d_done; after release request restarts with mem_req one cycle later.
- Fairness (MEMARB_FAIRNESS_EN, MAX_DSTREAK=4): d_req and i_req held continuously → 4 d_done pulses then one i_done, repeating; without macro, no i_done.
- LAT=1 back-to-back fetches with i_req held → i_done every 4 cycles, mem_addr tracks new i_addr each transaction.
